frequency_meter: RTL
====================

# frequency_meter

Measures an incoming, unrelated digital signal against the system clock and is the measuring counterpart of our clock-divider blocks. Two modes: frequency mode counts rising edges of `sig_in` inside a fixed gate window of `GATE_CYCLES` clk cycles; period mode counts clk cycles between two consecutive rising edges. Each completed measurement is reported as one `result` word with a one-cycle `valid` strobe. It is used to self-check divider outputs on the board and to measure external inputs for display.

## Interface
- `GATE_CYCLES`, default 50000000: gate window length in frequency mode and timeout in period mode, in clk cycles. Legal range is ≥2 and ≤2^COUNT_W−1.
- `COUNT_W`, default 27: width of `result` and of all internal counters.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  measurement enable, level.
- `mode`  in  1  0 = frequency, 1 = period. Sampled only on IDLE→run and on REPORT→run transitions.
- `sig_in`  in  1  measured signal, asynchronous to clk.
- `result`  out  COUNT_W  last measurement. Holds until the next REPORT.
- `valid`  out  1  one-cycle pulse; `result`/`ovf` updated in the same cycle.
- `ovf`  out  1  flag qualifying the current `result`: saturation or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input path: `sig_in` → 2-flop synchronizer (s1, s2) → s3. `rise` = s2 & ~s3. All flops reset to 0. A `sig_in` that is high through reset release therefore yields one `rise`.
- States: IDLE, ARM, MEASURE, REPORT. All outputs are registered.
- IDLE: counters are cleared. If `en`=1, the next state is MEASURE when mode=0, or ARM when mode=1.
- Frequency mode, MEASURE:
  - gate counter g runs 0..GATE_CYCLES−1, so the window is exactly GATE_CYCLES cycles.
  - edge counter e increments on `rise` and saturates at 2^COUNT_W−1; reaching saturation sets the sticky flag ovf_i.
  - A `rise` in the last window cycle (g=GATE_CYCLES−1) is counted.
  - After the last cycle → REPORT with result←e_final and ovf←ovf_i.
- Period mode:
  - ARM waits for a `rise`, with timeout counter t.
    - `rise` → MEASURE with p←1.
    - If t reaches GATE_CYCLES with no `rise` → REPORT with result←0, ovf←1.
  - MEASURE: p increments every cycle.
    - `rise` → REPORT with result←p. Edges at cycles t0 and t1 give result = t1−t0.
    - If p reaches GATE_CYCLES before a `rise` → REPORT with result←0, ovf←1.
- REPORT lasts one cycle, with `valid`=1.
  - If `en`=1, re-sample `mode` and go to MEASURE (mode 0) or ARM (mode 1). Otherwise go to IDLE.
  - In period mode the terminating edge is not reused as the next start edge.
- A `rise` during IDLE or REPORT is ignored.
- `en`=0 in ARM or MEASURE → IDLE next cycle. No `valid` is issued; `result` and `ovf` keep their old values.
- `mode` changes while a measurement is running are ignored.
- `rst`=0 at any clock edge wins over everything: state→IDLE and all outputs return to reset values.

## Timing
- Reset values: result=0, valid=0, ovf=0, busy=0, state=IDLE, s1=s2=s3=0.
- Synchronizer latency: a `sig_in` rise sampled at clk edge k produces `rise`=1 during cycle k+2 (after s2 updates at edge k+1).
- Frequency mode: with `en` first seen high in cycle c, busy=1 from c+1. The window is cycles c+1..c+GATE_CYCLES, and valid=1 in cycle c+GATE_CYCLES+1.
- Continuous frequency operation gives one `valid` every GATE_CYCLES+1 cycles. Edges in the REPORT cycle are lost.
- Period mode: valid=1 in the cycle after the terminating `rise`.
- `valid` is never high in two consecutive cycles.

## Test plan
- Frequency: GATE_CYCLES=100, COUNT_W=27, `sig_in` square wave of period 10 clk, `en` held high → `valid` every 101 cycles, each with result=10, ovf=0. Also check the first `valid` at cycle c+101.
- Period: mode=1, `sig_in` period 37 clk, stable → every `valid` carries result=37, ovf=0. Repeat with period 2 → result=2.
- Timeout: mode=1, GATE_CYCLES=100, `sig_in`=0 → `valid` 101 cycles after `en`, with result=0, ovf=1. Then a single edge followed by silence → result=0, ovf=1 after a further 100 cycles in MEASURE.
- Saturation: GATE_CYCLES=100, COUNT_W=4, `sig_in` period 4 (25 edges per window) → result=15, ovf=1. Next window with `sig_in` period 10 → result=10, ovf=0.
- Abort:
  - drop `en` at window cycle 50 → busy=0 next cycle, no `valid`, `result` unchanged.
  - re-assert `en` → a full fresh 100-cycle window.
- Reset mid-measurement: assert `rst`=0 in MEASURE → next cycle result=0, valid=0, ovf=0, busy=0. With `sig_in` held high across reset release → exactly one `rise`, 3 cycles later.

Source files
------------

// File: rtl/frequency_meter.sv
// ---------------------------------------------------------------------------
// frequency_meter
//
// Measures an asynchronous digital input against clk.
//   mode 0 (frequency): counts rising edges of sig_in in a window of
//                       GATE_CYCLES clk cycles.
//   mode 1 (period)   : counts clk cycles between two consecutive rising
//                       edges of sig_in, with a GATE_CYCLES timeout.
// Each completed measurement is reported once: result/ovf update in the
// same cycle as a one-cycle valid strobe.
//
// Parameters
//   GATE_CYCLES  gate window (mode 0) / timeout (mode 1), in clk cycles
//   COUNT_W      width of result and of the edge counter
// Ports
//   clk     in   system clock
//   rst     in   synchronous reset, active low
//   en      in   measurement enable (level)
//   mode    in   0 = frequency, 1 = period; sampled only when a run starts
//   sig_in  in   measured signal, asynchronous to clk
//   result  out  last measurement, held until the next report
//   valid   out  one-cycle strobe marking a new result
//   ovf     out  result saturated (mode 0) or timed out (mode 1)
//   busy    out  high in every state except IDLE
// ---------------------------------------------------------------------------
module frequency_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int COUNT_W     = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] result,
    output logic               valid,
    output logic               ovf,
    output logic               busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    // Gate/timeout/period counters must be able to hold GATE_CYCLES even
    // when result is configured narrower than the window length.
    localparam int GATE_BITS = $clog2(GATE_CYCLES + 1);
    localparam int GW        = (GATE_BITS > COUNT_W) ? GATE_BITS : COUNT_W;

    localparam logic [GW-1:0]      G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]      G_FULL = GW'(GATE_CYCLES);
    localparam logic [COUNT_W-1:0] E_MAX  = '1;

    logic               s1, s2, s3;
    logic               rise;
    logic [1:0]         state, nstate;
    logic               mode_r;
    logic [GW-1:0]      g;        // gate counter, frequency mode
    logic [GW-1:0]      t;        // arm timeout counter, period mode
    logic [GW-1:0]      p;        // period counter, period mode
    logic [COUNT_W-1:0] e;        // edge counter, frequency mode
    logic [COUNT_W-1:0] e_nx;
    logic               ovf_i;
    logic               ovf_nx;
    logic               p_wide;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating edge count including the edge of the current cycle, so an
    // edge in the last window cycle still lands in the reported value.
    assign e_nx   = (rise && (e != E_MAX)) ? e + COUNT_W'(1) : e;
    assign ovf_nx = ovf_i | (e_nx == E_MAX);

    // Period exceeds the result width (only possible when GW > COUNT_W).
    assign p_wide = (p >> COUNT_W) != '0;

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (en) nstate = mode ? ARM : MEASURE;
            end
            ARM: begin
                if (!en)              nstate = IDLE;
                else if (rise)        nstate = MEASURE;
                else if (t == G_LAST) nstate = REPORT;
            end
            MEASURE: begin
                if (!en) begin
                    nstate = IDLE;
                end else if (!mode_r) begin
                    if (g == G_LAST) nstate = REPORT;
                end else begin
                    if (rise || (p == G_FULL)) nstate = REPORT;
                end
            end
            default: begin
                nstate = en ? (mode ? ARM : MEASURE) : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            mode_r <= 1'b0;
            g      <= '0;
            t      <= '0;
            p      <= '0;
            e      <= '0;
            ovf_i  <= 1'b0;
        end else begin
            state <= nstate;
            busy  <= (nstate != IDLE);
            valid <= 1'b0;
            case (state)
                ARM: begin
                    t <= t + GW'(1);
                    if (nstate == MEASURE) p <= GW'(1);
                    if (nstate == REPORT) begin
                        result <= '0;
                        ovf    <= 1'b1;
                        valid  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!mode_r) begin
                        g     <= g + GW'(1);
                        e     <= e_nx;
                        ovf_i <= ovf_nx;
                        if (nstate == REPORT) begin
                            result <= e_nx;
                            ovf    <= ovf_nx;
                            valid  <= 1'b1;
                        end
                    end else begin
                        p <= p + GW'(1);
                        if (nstate == REPORT) begin
                            valid <= 1'b1;
                            if (rise && !p_wide) begin
                                result <= p[COUNT_W-1:0];
                                ovf    <= 1'b0;
                            end else if (rise) begin
                                result <= E_MAX;
                                ovf    <= 1'b1;
                            end else begin
                                result <= '0;
                                ovf    <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and REPORT: start every run from clean counters.
                    g     <= '0;
                    t     <= '0;
                    p     <= '0;
                    e     <= '0;
                    ovf_i <= 1'b0;
                    if (nstate != IDLE) mode_r <= mode;
                end
            endcase
        end
    end

endmodule
